// File: rtl/topk_result_collector.sv
// Captures streamed top-K vertex IDs into a local buffer and pops them to a slow host on rd_req_in rising edges.
// Optional TOPK_DEDUP_EN: drop a beat equal to the last stored entry.
module topk_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [15:0]           k_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  result_valid_in,
  input  logic                  rd_req_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  output logic [15:0]           count_out,
  output logic                  done_out,
  output logic                  overflow_out,
  output logic [1:0]            state_out
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [15:0]   DEPTH_K = 16'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_READOUT = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] keff_q, keff_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_req_q;
  logic          rise;
  logic          wr_en;
  logic          dup;

`ifdef TOPK_DEDUP_EN
  logic [PW-1:0] last_ptr;
  assign last_ptr = count_q - ONE;
  assign dup = (count_q != '0) && (result_in == mem_q[last_ptr[IW-1:0]]);
`else
  assign dup = 1'b0;
`endif

  assign rise = rd_req_in & ~rd_req_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    keff_d   = keff_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (start_in) begin
      // a beat coinciding with start is neither stored nor flagged
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = (k_in > DEPTH_K);
      keff_d   = (k_in > DEPTH_K) ? DEPTH_P : k_in[PW-1:0];
      if (k_in == 16'd0) begin
        state_d = S_READOUT;
        done_d  = 1'b1;
      end else begin
        state_d = S_COLLECT;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (result_valid_in && !dup) begin
            wr_en   = 1'b1;
            count_d = count_q + ONE;
            if (count_d == keff_q) begin
              state_d = S_READOUT;
              done_d  = 1'b1;
            end
          end
        end
        S_READOUT: begin
          if (result_valid_in) ovf_d = 1'b1;
          if (rise && rd_valid_q) begin
            rd_ptr_d = rd_ptr_q + ONE;
            if (rd_ptr_d == count_q) state_d = S_IDLE;
          end
        end
        default: begin
          if (result_valid_in) ovf_d = 1'b1;
        end
      endcase
    end
    rd_valid_d = (state_d == S_READOUT) && (rd_ptr_d < count_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      keff_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      keff_q     <= keff_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_req_q   <= rd_req_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[count_q[IW-1:0]] <= result_in;
  end

  assign rd_data_out  = rd_valid_q ? mem_q[rd_ptr_q[IW-1:0]] : '0;
  assign rd_valid_out = rd_valid_q;
  assign count_out    = 16'(count_q);
  assign done_out     = done_q;
  assign overflow_out = ovf_q;
  assign state_out    = state_q;

endmodule
